cerr_thresh_monitor: RTL and testbench
======================================

Name: cerr_thresh_monitor

Overview:
- Consumer stage for the correctable-error threshold programming channel (cerr_threshold_vld / cerr_threshold_ack / cerr_threshold[7:0]) in the BIST clock domain.
- Accepts a threshold over a valid/ack handshake.
- Counts correctable-error event pulses from the BIST/ECC datapath.
- Raises a level interrupt when the count reaches the programmed threshold, until software clears it.

Parameters:
- CNT_W, 16, width of error counter; must be >= 8.
- THR_W, 8, width of threshold bus.

Ports:
- bist_clk  input  1  clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- cerr_threshold_vld  input  1  threshold valid from programmer; held until ack seen.
- cerr_threshold  input  THR_W  threshold value; stable while vld high.
- cerr_threshold_ack  output  1  one-cycle acknowledge of captured threshold.
- cerr_event  input  1  single-cycle pulse per correctable error (one per cycle max).
- cerr_int_clr  input  1  one-cycle clear of interrupt and counter.
- cerr_int  output  1  level interrupt; threshold reached.
- cerr_count  output  CNT_W  current error count.
- cerr_ovf  output  1  sticky; counter saturated.
- thr_reg  output  THR_W  currently programmed threshold.
- state_o  output  2  FSM state: 0 DISABLED, 1 ARMED, 2 TRIPPED.

Behaviour:
- Interface: one clock (bist_clk); reset is asynchronous and active-high.
- Reset (async assert, sync release):
  - thr_reg=0, cerr_count=0, cerr_int=0, cerr_ovf=0, cerr_threshold_ack=0, state=DISABLED.
  - Reset mid-handshake drops the pending ack; the programmer must re-present.
- Handshake:
  - Capture when cerr_threshold_vld=1 and cerr_threshold_ack=0.
  - thr_reg <= cerr_threshold on that edge; cerr_threshold_ack=1 for exactly the following cycle.
  - vld still high during the ack cycle is ignored.
  - A vld held beyond the ack cycle is a new request: captured again, re-acked.
  - Back-to-back requests therefore complete at most every 2 cycles.
- Restart: a capture or a cerr_int_clr.
  - count_next = cerr_event ? 1 : 0.
  - cerr_int=0, cerr_ovf=0.
  - If both occur in one cycle, the capture's threshold applies and the restart happens once.
- Counting (no restart):
  - cerr_event increments cerr_count by 1 in every state, including DISABLED.
  - Saturates at 2^CNT_W-1; an event at max holds the count and sets cerr_ovf (sticky until restart/reset).
- Trip compare:
  - count_next >= zero-extended thr_reg, with thr_reg != 0.
  - Evaluated on the same edge the count updates; cerr_int rises on the same edge the count reaches the threshold (zero added latency).
  - Applies to restart values too: threshold 1 with an event during restart trips immediately.
- FSM (registered; next state from thr value after capture):
  - DISABLED: thr_reg==0; cerr_int never set; counting continues. Capture of nonzero -> ARMED.
  - ARMED: trip compare true -> TRIPPED, cerr_int<=1. Capture of 0 -> DISABLED. Capture of nonzero -> ARMED (restart).
  - TRIPPED:
    - cerr_int held at 1; counting continues (saturating).
    - cerr_int_clr -> ARMED, or immediately TRIPPED if the restart value already meets the threshold.
    - Capture -> ARMED/DISABLED/TRIPPED per the new threshold and restart value.
  - cerr_int_clr in DISABLED or ARMED: restarts the counter only.
- Unused encoding 3: recovers to DISABLED next cycle, with outputs as for reset except thr_reg held.
- All outputs are registered; no combinational path input->output.

Test Plan:
- Reset then program: vld=1, thr=0x05 -> ack high exactly 1 cycle after capture, thr_reg=5, state ARMED, count=0.
- Trip: thr=3, three cerr_event pulses on cycles 10, 12, 15 -> cerr_count=3 and cerr_int=1 on edge of cycle 15; further 2 events -> count=5, int stays 1.
- Clear with simultaneous event: in TRIPPED with thr=1, assert cerr_int_clr and cerr_event same cycle -> count=1, state TRIPPED, cerr_int=1 (re-trip); clr alone with thr=3 -> count=0, ARMED, int=0.
- Disable: program thr=0, send 300 events -> count=300, cerr_int never asserts, state DISABLED.
- Saturation: CNT_W=8, thr=0, 257 events -> cerr_count=255, cerr_ovf=1 after the 256th event; reprogram thr=4 -> ovf=0, count=0.
- Handshake/reset corner: vld held high 4 cycles -> two captures, acks on cycles 2 and 4. Separately, assert reset during the ack cycle -> ack=0 immediately (async), thr_reg=0, state DISABLED.

Source files
------------

// File: rtl/cerr_thresh_monitor.sv
// rtl/cerr_thresh_monitor.sv - correctable-error threshold monitor with programmable trip level
//
// Purpose: accepts a threshold over a vld/ack handshake, counts correctable-error
// pulses and raises a level interrupt once the count reaches the threshold.
// Ports:
//   bist_clk, reset            clock, async active-high reset
//   cerr_threshold_vld/_ack    threshold handshake (ack is one cycle after capture)
//   cerr_threshold [THR_W]     threshold value
//   cerr_event                 one pulse per correctable error
//   cerr_int_clr               clears interrupt and restarts counter
//   cerr_int, cerr_count, cerr_ovf, thr_reg, state_o   registered status outputs
module cerr_thresh_monitor #(
    parameter int CNT_W = 16,
    parameter int THR_W = 8
) (
    input  logic             bist_clk,
    input  logic             reset,
    input  logic             cerr_threshold_vld,
    input  logic [THR_W-1:0] cerr_threshold,
    output logic             cerr_threshold_ack,
    input  logic             cerr_event,
    input  logic             cerr_int_clr,
    output logic             cerr_int,
    output logic [CNT_W-1:0] cerr_count,
    output logic             cerr_ovf,
    output logic [THR_W-1:0] thr_reg,
    output logic [1:0]       state_o
);

    localparam int CMP_W = (CNT_W > THR_W) ? CNT_W : THR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_TRIPPED  = 2'd2,
        ST_BAD      = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [THR_W-1:0] thr_next;
    logic [CNT_W-1:0] count_next;
    logic             ovf_next;
    logic             int_next;
    logic             ack_next;
    logic             capture;
    logic             restart;
    logic             trip;

    // The ack cycle itself never captures, so a held vld re-captures every other cycle.
    assign capture = cerr_threshold_vld && !cerr_threshold_ack;
    assign restart = capture || cerr_int_clr;
    assign state_o = state;

    always_comb begin
        thr_next   = thr_reg;
        count_next = cerr_count;
        ovf_next   = cerr_ovf;
        int_next   = 1'b0;
        ack_next   = 1'b0;
        trip       = 1'b0;
        state_next = ST_DISABLED;
        if (state == ST_BAD) begin
            // Recover like reset but keep the programmed threshold.
            count_next = '0;
            ovf_next   = 1'b0;
        end else begin
            if (capture) begin
                thr_next = cerr_threshold;
            end
            if (restart) begin
                count_next = CNT_W'(cerr_event);
                ovf_next   = 1'b0;
            end else if (cerr_event) begin
                if (cerr_count == CNT_MAX) begin
                    ovf_next = 1'b1;
                end else begin
                    count_next = cerr_count + CNT_W'(1);
                end
            end
            ack_next = capture;
            // Compare against the post-update count so the interrupt rises on the same edge.
            trip = (thr_next != '0) && (CMP_W'(count_next) >= CMP_W'(thr_next));
            if (thr_next == '0) begin
                state_next = ST_DISABLED;
            end else if (state == ST_TRIPPED && !restart) begin
                state_next = ST_TRIPPED;
            end else if (trip) begin
                state_next = ST_TRIPPED;
            end else begin
                state_next = ST_ARMED;
            end
            int_next = (state_next == ST_TRIPPED);
        end
    end

    always_ff @(posedge bist_clk or posedge reset) begin
        if (reset) begin
            state              <= ST_DISABLED;
            thr_reg            <= '0;
            cerr_count         <= '0;
            cerr_ovf           <= 1'b0;
            cerr_int           <= 1'b0;
            cerr_threshold_ack <= 1'b0;
        end else begin
            state              <= state_next;
            thr_reg            <= thr_next;
            cerr_count         <= count_next;
            cerr_ovf           <= ovf_next;
            cerr_int           <= int_next;
            cerr_threshold_ack <= ack_next;
        end
    end

endmodule

// File: tb/tb_cerr_thresh_monitor.sv
// tb/tb_cerr_thresh_monitor.sv - self-checking bench for cerr_thresh_monitor
module tb_cerr_thresh_monitor;

    logic       bist_clk = 1'b0;
    logic       reset    = 1'b1;
    logic       vld      = 1'b0;
    logic [7:0] thr      = 8'd0;
    logic       ev       = 1'b0;
    logic       clr      = 1'b0;

    logic        ack16, int16, ovf16, ack8, int8, ovf8;
    logic [15:0] count16;
    logic [7:0]  count8, thr16, thr8;
    logic [1:0]  st16, st8;

    always #5 bist_clk = ~bist_clk;

    cerr_thresh_monitor #(.CNT_W(16), .THR_W(8)) dut16 (
        .bist_clk(bist_clk), .reset(reset), .cerr_threshold_vld(vld), .cerr_threshold(thr),
        .cerr_threshold_ack(ack16), .cerr_event(ev), .cerr_int_clr(clr), .cerr_int(int16),
        .cerr_count(count16), .cerr_ovf(ovf16), .thr_reg(thr16), .state_o(st16));

    cerr_thresh_monitor #(.CNT_W(8), .THR_W(8)) dut8 (
        .bist_clk(bist_clk), .reset(reset), .cerr_threshold_vld(vld), .cerr_threshold(thr),
        .cerr_threshold_ack(ack8), .cerr_event(ev), .cerr_int_clr(clr), .cerr_int(int8),
        .cerr_count(count8), .cerr_ovf(ovf8), .thr_reg(thr8), .state_o(st8));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: index 0 is the 16-bit counter, index 1 the 8-bit one.
    int m_max[2] = '{65535, 255};
    int m_cnt[2];
    int m_thr[2];
    bit m_ack[2];
    bit m_ovf[2];
    bit m_tripped[2];

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_thr[i] = 0; m_ack[i] = 0; m_ovf[i] = 0; m_tripped[i] = 0;
        end
    endtask

    task automatic model_step(input bit v, input int t, input bit e, input bit c);
        for (int i = 0; i < 2; i++) begin
            bit cap, rs, hit;
            cap = v && !m_ack[i];
            rs  = cap || c;
            if (cap) m_thr[i] = t;
            if (rs) begin
                m_cnt[i] = e ? 1 : 0;
                m_ovf[i] = 0;
            end else if (e) begin
                if (m_cnt[i] == m_max[i]) m_ovf[i] = 1;
                else m_cnt[i] = m_cnt[i] + 1;
            end
            hit = (m_thr[i] != 0) && (m_cnt[i] >= m_thr[i]);
            m_tripped[i] = rs ? hit : (m_tripped[i] || hit);
            m_ack[i] = cap;
        end
    endtask

    function automatic int m_state(input int i);
        if (m_thr[i] == 0) return 0;
        return m_tripped[i] ? 2 : 1;
    endfunction

    task automatic check_model();
        chk("count16", count16, m_cnt[0]);
        chk("int16",   int16,   m_tripped[0]);
        chk("ovf16",   ovf16,   m_ovf[0]);
        chk("thr16",   thr16,   m_thr[0]);
        chk("state16", st16,    m_state(0));
        chk("ack16",   ack16,   m_ack[0]);
        chk("count8",  count8,  m_cnt[1]);
        chk("int8",    int8,    m_tripped[1]);
        chk("ovf8",    ovf8,    m_ovf[1]);
        chk("thr8",    thr8,    m_thr[1]);
        chk("state8",  st8,     m_state(1));
        chk("ack8",    ack8,    m_ack[1]);
    endtask

    task automatic step(input bit v, input logic [7:0] t, input bit e, input bit c);
        vld = v; thr = t; ev = e; clr = c;
        @(posedge bist_clk);
        model_step(v, int'(t), e, c);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1; vld = 1'b0; ev = 1'b0; clr = 1'b0; thr = 8'd0;
        @(negedge bist_clk);
        @(negedge bist_clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_model();
    endtask

    typedef struct {
        bit       v;
        bit [7:0] t;
        bit       e;
        bit       c;
        int       cnt;
        bit       irq;
        int       st;
        bit       ak;
        int       th;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1, 8'd5, 0, 0, 0, 0, 1, 1, 5};
        tbl[1]  = '{0, 8'd0, 0, 0, 0, 0, 1, 0, 5};
        tbl[2]  = '{1, 8'd3, 0, 0, 0, 0, 1, 1, 3};
        tbl[3]  = '{0, 8'd0, 1, 0, 1, 0, 1, 0, 3};
        tbl[4]  = '{0, 8'd0, 0, 0, 1, 0, 1, 0, 3};
        tbl[5]  = '{0, 8'd0, 1, 0, 2, 0, 1, 0, 3};
        tbl[6]  = '{0, 8'd0, 1, 0, 3, 1, 2, 0, 3};
        tbl[7]  = '{0, 8'd0, 1, 0, 4, 1, 2, 0, 3};
        tbl[8]  = '{0, 8'd0, 1, 0, 5, 1, 2, 0, 3};
        tbl[9]  = '{0, 8'd0, 0, 1, 0, 0, 1, 0, 3};
        tbl[10] = '{1, 8'd1, 1, 0, 1, 1, 2, 1, 1};
        tbl[11] = '{0, 8'd0, 1, 1, 1, 1, 2, 0, 1};
        tbl[12] = '{1, 8'd3, 0, 1, 0, 0, 1, 1, 3};
        tbl[13] = '{1, 8'd3, 1, 0, 1, 0, 1, 0, 3};
        tbl[14] = '{1, 8'd0, 0, 0, 0, 0, 0, 1, 0};
        tbl[15] = '{0, 8'd0, 1, 0, 1, 0, 0, 0, 0};

        model_reset();
        #2;
        chk("rst_count", count16, 0);
        chk("rst_int",   int16,   0);
        chk("rst_ack",   ack16,   0);
        chk("rst_state", st16,    0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].t, tbl[i].e, tbl[i].c);
            chk($sformatf("tbl%0d_count", i), count16, tbl[i].cnt);
            chk($sformatf("tbl%0d_int", i),   int16,   tbl[i].irq);
            chk($sformatf("tbl%0d_state", i), st16,    tbl[i].st);
            chk($sformatf("tbl%0d_ack", i),   ack16,   tbl[i].ak);
            chk($sformatf("tbl%0d_thr", i),   thr16,   tbl[i].th);
        end

        // Trip at threshold 3 with sparse events.
        do_reset();
        step(1, 8'd3, 0, 0);
        for (int c = 0; c < 16; c++) begin
            step(0, 8'd0, (c == 10 || c == 12 || c == 15), 0);
            if (c == 14) chk("trip_pre_int", int16, 0);
        end
        chk("trip_count", count16, 3);
        chk("trip_int", int16, 1);
        step(0, 8'd0, 1, 0);
        step(0, 8'd0, 1, 0);
        chk("trip_count5", count16, 5);
        chk("trip_int_hold", int16, 1);

        // Held vld: captures on cycles 1 and 3, acks on cycles 2 and 4.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(1, 8'd7, 0, 0);
            chk($sformatf("hs_ack%0d", c), ack16, (c % 2 == 0) ? 1 : 0);
        end
        step(0, 8'd0, 0, 0);

        // Disabled counting and 8-bit saturation.
        do_reset();
        step(1, 8'd0, 0, 0);
        step(0, 8'd0, 0, 0);
        for (int k = 0; k < 300; k++) begin
            step(0, 8'd0, 1, 0);
            if (k == 254) chk("sat_pre_ovf", ovf8, 0);
            if (k == 255) begin
                chk("sat_count8", count8, 255);
                chk("sat_ovf8", ovf8, 1);
            end
        end
        chk("dis_count", count16, 300);
        chk("dis_int", int16, 0);
        chk("dis_state", st16, 0);
        step(1, 8'd4, 0, 0);
        chk("reprog_ovf8", ovf8, 0);
        chk("reprog_count8", count8, 0);
        step(0, 8'd0, 0, 0);

        // Reset during the ack cycle drops the ack asynchronously.
        step(1, 8'd9, 0, 0);
        chk("ra_ack_before", ack16, 1);
        reset = 1'b1;
        #1;
        chk("ra_ack", ack16, 0);
        chk("ra_thr", thr16, 0);
        chk("ra_state", st16, 0);
        chk("ra_count", count16, 0);
        model_reset();
        vld = 1'b0;
        @(negedge bist_clk);
        reset = 1'b0;
        #1;
        check_model();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, 8'($urandom_range(0, 6)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
